// File: rtl/logic_gate_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : logic_gate_pipe
//  Description : Two-stage valid/ready pipeline applying one of eight bitwise
//                logic operations to two WIDTH-bit operands, with a registered
//                OR-reduction flag of the result.
//                Optional macro GATE_STATS_EN adds a saturating output
//                transaction counter on port txn_count.
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_gate_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             y_red
`ifdef GATE_STATS_EN
   ,
   output logic [CNT_W-1:0] txn_count
`endif
);

   // Operation select encoding
   localparam logic [2:0] c_op_and  = 3'b000;
   localparam logic [2:0] c_op_or   = 3'b001;
   localparam logic [2:0] c_op_xor  = 3'b010;
   localparam logic [2:0] c_op_nand = 3'b011;
   localparam logic [2:0] c_op_nor  = 3'b100;
   localparam logic [2:0] c_op_xnor = 3'b101;
   localparam logic [2:0] c_op_nota = 3'b110;
   localparam logic [2:0] c_op_pass = 3'b111;

   // Stage 1 holds the raw operands; stage 2 holds the computed result.
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q,     s1_a_d;
   logic [WIDTH-1:0] s1_b_q,     s1_b_d;
   logic [2:0]       s1_op_q,    s1_op_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] y_q,        y_d;
   logic             y_red_q,    y_red_d;

   logic             w_s2_ready;
   logic             w_in_fire;
   logic             w_s1_adv;
   logic             w_out_fire;
   logic [WIDTH-1:0] w_result;

   // The eight gate functions; NOT/PASS ignore operand b.
   function automatic logic [WIDTH-1:0] gate_fn(
      input logic [2:0]       sel,
      input logic [WIDTH-1:0] x,
      input logic [WIDTH-1:0] z
   );
      logic [WIDTH-1:0] r;
      r = '0;
      case (sel)
         c_op_and  : r = x & z;
         c_op_or   : r = x | z;
         c_op_xor  : r = x ^ z;
         c_op_nand : r = ~(x & z);
         c_op_nor  : r = ~(x | z);
         c_op_xnor : r = ~(x ^ z);
         c_op_nota : r = ~x;
         c_op_pass : r = x;
         default   : r = '0;
      endcase
      return r;
   endfunction

   // Ready chain and handshake events; result is taken only from stage-1 regs.
   always_comb begin
      w_s2_ready = !out_valid_q || out_ready;
      in_ready   = !s1_valid_q || w_s2_ready;
      w_in_fire  = in_valid && in_ready;
      w_s1_adv   = s1_valid_q && w_s2_ready;
      w_out_fire = out_valid_q && out_ready;
      w_result   = gate_fn(s1_op_q, s1_a_q, s1_b_q);
   end

   // Next-state for both stages: refill, advance and drain can all coincide.
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s1_op_d     = s1_op_q;
      out_valid_d = out_valid_q;
      y_d         = y_q;
      y_red_d     = y_red_q;

      if (w_in_fire) begin
         s1_valid_d = 1'b1;
         s1_a_d     = a;
         s1_b_d     = b;
         s1_op_d    = op;
      end else if (w_s1_adv) begin
         s1_valid_d = 1'b0;
      end

      if (w_s1_adv) begin
         out_valid_d = 1'b1;
         y_d         = w_result;
         y_red_d     = |w_result;
      end else if (w_out_fire) begin
         out_valid_d = 1'b0;
      end
   end

   // Pipeline registers; reset discards everything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_op_q     <= '0;
         out_valid_q <= 1'b0;
         y_q         <= '0;
         y_red_q     <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_op_q     <= s1_op_d;
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
         y_red_q     <= y_red_d;
      end
   end

   assign out_valid = out_valid_q;
   assign y         = y_q;
   assign y_red     = y_red_q;

`ifdef GATE_STATS_EN
   logic [CNT_W-1:0] txn_count_q, txn_count_d;

   // Count output transfers, sticking at all-ones rather than wrapping.
   always_comb begin
      txn_count_d = txn_count_q;
      if (w_out_fire && (txn_count_q != {CNT_W{1'b1}})) begin
         txn_count_d = txn_count_q + CNT_W'(1);
      end
   end

   // Counter register, cleared with the rest of the pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txn_count_q <= '0;
      end else begin
         txn_count_q <= txn_count_d;
      end
   end

   assign txn_count = txn_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_gate_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logic_gate_pipe
//  Description : Scoreboard bench for logic_gate_pipe (WIDTH=8). Define
//                GATE_STATS_EN to also exercise txn_count with CNT_W=2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_gate_pipe;

   localparam int W     = 8;
   localparam int CNT_W = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [2:0]   op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] y;
   logic         y_red;
`ifdef GATE_STATS_EN
   logic [CNT_W-1:0] txn_count;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [W:0] sb[$];        // expected {y_red, y}
   int         pop_cyc[$];   // cycle stamp of each output transfer
   bit         prev_stall = 1'b0;
   logic [W-1:0] prev_y;
   logic       prev_red;
   int         exp_cnt = 0;

   logic_gate_pipe #(
      .WIDTH(W),
      .CNT_W(CNT_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .op       (op),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .y        (y),
      .y_red    (y_red)
`ifdef GATE_STATS_EN
      ,
      .txn_count(txn_count)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Reference: each op is a per-bit truth table indexed by {a_bit, b_bit}.
   function automatic logic [W:0] model(input logic [2:0] o,
                                        input logic [W-1:0] x,
                                        input logic [W-1:0] z);
      logic [3:0]   tt;
      logic [W-1:0] r;
      case (o)
         3'd0: tt = 4'b1000;  // AND
         3'd1: tt = 4'b1110;  // OR
         3'd2: tt = 4'b0110;  // XOR
         3'd3: tt = 4'b0111;  // NAND
         3'd4: tt = 4'b0001;  // NOR
         3'd5: tt = 4'b1001;  // XNOR
         3'd6: tt = 4'b0011;  // NOT a
         default: tt = 4'b1100;  // PASS a
      endcase
      for (int i = 0; i < W; i++) r[i] = tt[{x[i], z[i]}];
      return {(r != '0), r};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // One cycle of stimulus: drive at negedge, record acceptance before the edge.
   task automatic drive(input bit v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [2:0] iop, input bit ordy, output bit acc);
      @(negedge clk);
      in_valid  = v;
      a         = ia;
      b         = ib;
      op        = iop;
      out_ready = ordy;
      #1;
      acc = v && in_ready && rst_n;
      if (acc) sb.push_back(model(iop, ia, ib));
   endtask

   task automatic idle(input bit ordy);
      bit acc;
      drive(1'b0, '0, '0, 3'd0, ordy, acc);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 50 && sb.size() != 0; i++) idle(1'b1);
      idle(1'b1);
      check("drain_pending", 64'(sb.size()), 64'd0);
   endtask

   always @(negedge rst_n) begin
      prev_stall = 1'b0;
      exp_cnt    = 0;
   end

   // Monitor: pops the scoreboard on every output transfer.
   always @(negedge clk) begin
      logic [W:0] exp_v;
      #2;
      if (rst_n) begin
`ifdef GATE_STATS_EN
         check("txn_count", 64'(txn_count), 64'(exp_cnt));
`endif
         if (prev_stall) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_hold", 64'({y_red, y}), 64'({prev_red, prev_y}));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_out", 64'({y_red, y}), 64'h1ff);
            end else begin
               exp_v = sb.pop_front();
               check("result", 64'({y_red, y}), 64'(exp_v));
            end
            pop_cyc.push_back(cyc);
            if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
         end
         prev_stall = out_valid && !out_ready;
         prev_y     = y;
         prev_red   = y_red;
      end
   end

   initial begin
      bit acc;
      int n0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      op        = '0;
      out_ready = 1'b1;

      // Reset state
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_y", 64'(y), 64'd0);
      check("rst_y_red", 64'(y_red), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic OR with exact latency: result appears after the second edge
      drive(1'b1, 8'hA5, 8'h0F, 3'b001, 1'b1, acc);
      check("or_accept", 64'(acc), 64'd1);
      idle(1'b1);
      check("or_not_early", 64'(out_valid), 64'd0);
      idle(1'b1);
      check("or_valid", 64'(out_valid), 64'd1);
      check("or_y", 64'(y), 64'hAF);
      check("or_y_red", 64'(y_red), 64'd1);
      wait_drain();

      // All ops back-to-back, one result per cycle
      n0 = pop_cyc.size();
      for (int i = 0; i < 8; i++) drive(1'b1, 8'hCC, 8'hAA, 3'(i), 1'b1, acc);
      wait_drain();
      check("ops_count", 64'(pop_cyc.size() - n0), 64'd8);
      if (pop_cyc.size() - n0 == 8)
         check("ops_no_gap", 64'(pop_cyc[n0 + 7] - pop_cyc[n0]), 64'd7);

      // Backpressure: two accepted, third blocked until out_ready rises
      drive(1'b1, 8'h3C, 8'h5A, 3'b000, 1'b0, acc);
      check("bp_acc1", 64'(acc), 64'd1);
      drive(1'b1, 8'h3C, 8'h5A, 3'b010, 1'b0, acc);
      check("bp_acc2", 64'(acc), 64'd1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'h3C, 8'h5A, 3'b001, 1'b0, acc);
         check("bp_blocked", 64'(acc), 64'd0);
         check("bp_y_first", 64'(y), 64'h18);
      end
      n0 = pop_cyc.size();
      drive(1'b1, 8'h3C, 8'h5A, 3'b001, 1'b1, acc);
      check("bp_acc3", 64'(acc), 64'd1);
      wait_drain();
      check("bp_count", 64'(pop_cyc.size() - n0), 64'd3);
      if (pop_cyc.size() - n0 == 3)
         check("bp_no_gap", 64'(pop_cyc[n0 + 2] - pop_cyc[n0]), 64'd2);

      // Zero result clears the reduction flag
      drive(1'b1, 8'hFF, 8'hFF, 3'b010, 1'b1, acc);
      idle(1'b1);
      idle(1'b1);
      check("zero_y", 64'({y_red, y}), 64'h000);
      wait_drain();

      // Reset mid-stream with two transactions in flight
      drive(1'b1, 8'h12, 8'h34, 3'b001, 1'b0, acc);
      drive(1'b1, 8'h56, 8'h78, 3'b001, 1'b0, acc);
      idle(1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_ready", 64'(in_ready), 64'd1);
      sb.delete();
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         idle(1'b1);
         check("post_rst_no_stale", 64'(out_valid), 64'd0);
      end

      // Randomised traffic with random backpressure
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0), acc);
      end
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
      $fatal(1);
   end

endmodule
`default_nettype wire
